// File: rtl/mac_fir_pkg.sv
// Shared definitions for the time-multiplexed FIR (mac_fir): FSM encoding,
// DSP width limits and the output round/narrow helper.
// Build option: MAC_FIR_SATURATE_EN clamps the narrowed output instead of wrapping.
package mac_fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Port widths of the mult_add DSP stage.
  localparam int MAX_DATA_W  = 18;
  localparam int MAX_COEFF_W = 25;
  localparam int MAX_ACC_W   = 48;

  // Round-half-up arithmetic shift, then narrow to out_w bits. The result is
  // returned sign-extended to MAX_ACC_W; callers keep the low out_w bits.
  function automatic logic signed [MAX_ACC_W-1:0] round_narrow(
    input logic signed [MAX_ACC_W-1:0] acc,
    input int                          shift,
    input int                          out_w
  );
    logic signed [MAX_ACC_W-1:0] rnd;
    logic signed [MAX_ACC_W-1:0] r;
`ifdef MAC_FIR_SATURATE_EN
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lo;
`endif
    rnd = '0;
    if (shift > 0) rnd = MAX_ACC_W'(1) << (shift - 1);
    r = (acc + rnd) >>> shift;
`ifdef MAC_FIR_SATURATE_EN
    hi = (MAX_ACC_W'(1) << (out_w - 1)) - MAX_ACC_W'(1);
    lo = ~hi;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
`else
    // Keep only out_w bits (two's-complement wrap), re-extended for the caller.
    r = (r <<< (MAX_ACC_W - out_w)) >>> (MAX_ACC_W - out_w);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mac_fir_mult_add.sv
// mult_add: combinational signed DSP stage, p = a*b + c. All operands are
// treated as signed and sign-extended to the P width.
module mult_add #(
  parameter int A_WIDTH = 25,
  parameter int B_WIDTH = 18,
  parameter int C_WIDTH = 48,
  parameter int P_WIDTH = 48
) (
  input  logic [A_WIDTH-1:0] a,
  input  logic [B_WIDTH-1:0] b,
  input  logic [C_WIDTH-1:0] c,
  output logic [P_WIDTH-1:0] p
);

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;

  // Signed multiply-add; size casts of signed operands sign-extend.
  always_comb begin
    prod = $signed(a) * $signed(b);
    p    = P_WIDTH'(prod) + P_WIDTH'($signed(c));
  end

endmodule

// File: rtl/mac_fir.sv
// mac_fir: sequential FIR, one tap per clock through a single mult_add.
// Build option: MAC_FIR_SATURATE_EN (see mac_fir_pkg::round_narrow).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. s_ready is high only in IDLE; m_valid, once high, stays high with
// m_data stable until the edge where m_ready is seen high.
module mac_fir
  import mac_fir_pkg::*;
#(
  parameter int N_TAPS      = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 25,
  parameter int ACC_WIDTH   = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int OUT_SHIFT   = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [OUT_WIDTH-1:0]      m_data,
  input  logic                      coeff_we,
  input  logic [$clog2(N_TAPS)-1:0] coeff_addr,
  input  logic [COEFF_WIDTH-1:0]    coeff_data,
  output logic                      coeff_busy,
  output logic [1:0]                dbg_state_o
);

  localparam int AW = $clog2(N_TAPS);
  localparam logic [AW-1:0] K_LAST = AW'(N_TAPS - 1);

  state_e                 state_q, state_d;
  logic [AW-1:0]          k_q;
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_idx;
  logic                   last_tap;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic                   m_valid_q;
  logic [OUT_WIDTH-1:0]   m_data_q;
  logic [DATA_WIDTH-1:0]  delay_q [N_TAPS];
  logic [COEFF_WIDTH-1:0] coeff_q [N_TAPS];
  logic [COEFF_WIDTH-1:0] mac_a;
  logic [DATA_WIDTH-1:0]  mac_b;
  logic [ACC_WIDTH-1:0]   mac_c;
  logic [ACC_WIDTH-1:0]   mac_p;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: accept a sample, walk all taps, hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (s_valid)               state_d = ST_RUN;
      ST_RUN:  if (last_tap)              state_d = ST_DONE;
      ST_DONE: if (m_valid_q && m_ready)  state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and MAC operand selection; tap 0 reads the newest sample.
  always_comb begin
    s_ready    = (state_q == ST_IDLE);
    coeff_busy = (state_q == ST_RUN);
    last_tap   = (k_q == K_LAST);
    rd_idx     = wr_ptr_q - k_q;
    mac_a      = coeff_q[k_q];
    mac_b      = delay_q[rd_idx];
    mac_c      = (k_q == '0) ? '0 : acc_q;
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign dbg_state_o = state_q;

  mult_add #(
    .A_WIDTH(COEFF_WIDTH),
    .B_WIDTH(DATA_WIDTH),
    .C_WIDTH(ACC_WIDTH),
    .P_WIDTH(ACC_WIDTH)
  ) u_mult_add (
    .a(mac_a),
    .b(mac_b),
    .c(mac_c),
    .p(mac_p)
  );

  // Tap counter, write pointer and accumulator; pointer advances after the last tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      wr_ptr_q <= '0;
      acc_q    <= '0;
    end else begin
      k_q <= (state_q == ST_RUN) ? k_q + 1'b1 : '0;
      if (state_q == ST_RUN) begin
        acc_q <= mac_p;
        if (last_tap) wr_ptr_q <= wr_ptr_q + 1'b1;
      end
    end
  end

  // Delay line and coefficient bank; coefficient writes are dropped during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TAPS; i++) begin
        delay_q[i] <= '0;
        coeff_q[i] <= '0;
      end
    end else begin
      if (state_q == ST_IDLE && s_valid) delay_q[wr_ptr_q] <= s_data;
      if (coeff_we && state_q != ST_RUN) coeff_q[coeff_addr] <= coeff_data;
    end
  end

  // Output register: first DONE cycle loads the rounded result, handshake clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (state_q == ST_DONE) begin
      if (!m_valid_q) begin
        m_valid_q <= 1'b1;
        m_data_q  <= OUT_WIDTH'(round_narrow(MAX_ACC_W'($signed(acc_q)), OUT_SHIFT, OUT_WIDTH));
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_fir.sv
// Testbench for mac_fir: two instances (OUT_SHIFT 0 and 1, N_TAPS 4) driven
// from shared stimulus tasks, with a negedge monitor popping expected results.
module tb_mac_fir;

  localparam int N_TAPS = 4;
  localparam int DW     = 16;
  localparam int CW     = 25;
  localparam int OW     = 16;
  localparam int LAT    = N_TAPS + 2;  // negedges from accept edge to first m_valid sample

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b1;
  logic          coeff_we = 1'b0;
  logic [1:0]    coeff_addr = '0;
  logic [CW-1:0] coeff_data = '0;
  int            sel = 0;

  logic          s_valid0, s_valid1, we0, we1;
  logic          s_ready0, s_ready1, m_valid0, m_valid1, busy0, busy1;
  logic [OW-1:0] m_data0, m_data1;
  logic [1:0]    dbg0, dbg1;

  assign s_valid0 = s_valid && (sel == 0);
  assign s_valid1 = s_valid && (sel == 1);
  assign we0      = coeff_we && (sel == 0);
  assign we1      = coeff_we && (sel == 1);

  mac_fir #(.N_TAPS(N_TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ACC_WIDTH(48),
            .OUT_WIDTH(OW), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid0), .s_ready(s_ready0), .s_data(s_data),
    .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0), .coeff_we(we0),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .coeff_busy(busy0), .dbg_state_o(dbg0));

  mac_fir #(.N_TAPS(N_TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ACC_WIDTH(48),
            .OUT_WIDTH(OW), .OUT_SHIFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .coeff_we(we1),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .coeff_busy(busy1), .dbg_state_o(dbg1));

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q0[$];
  logic [OW-1:0] exp_q1[$];
  int            lat_q0[$];
  int            lat_q1[$];
  int            tests = 0;
  int            fails = 0;
  int            ncyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic          prev_v [2];
  logic          mv;
  logic [OW-1:0] md;
  logic [OW-1:0] e;
  int            acc_cyc;

  initial begin
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
  end

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (!rst_n) begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mv = (i == 0) ? m_valid0 : m_valid1;
        md = (i == 0) ? m_data0 : m_data1;
        if (mv && !prev_v[i]) begin
          if ((i == 0 ? lat_q0.size() : lat_q1.size()) == 0) fail_now("unexpected m_valid");
          else begin
            acc_cyc = (i == 0) ? lat_q0.pop_front() : lat_q1.pop_front();
            check("latency", ncyc - acc_cyc, LAT);
          end
        end
        if (mv && m_ready) begin
          if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) fail_now("unexpected output");
          else begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(i == 0 ? "m_data dut0" : "m_data dut1", longint'($signed(md)), longint'($signed(e)));
          end
        end
        prev_v[i] = mv;
      end
    end
  end

  // ---------------- driver tasks (called #1 after a rising edge) ----------------
  function automatic logic cur_ready();
    return (sel == 0) ? s_ready0 : s_ready1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coeff(input logic [1:0] addr, input logic [CW-1:0] data);
    coeff_we   = 1'b1;
    coeff_addr = addr;
    coeff_data = data;
    tick();
    coeff_we   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [OW-1:0] exp, input bit push);
    int budget;
    budget = 0;
    while (!cur_ready() && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) begin
      fail_now("s_ready timeout");
      return;
    end
    s_data  = x;
    s_valid = 1'b1;
    @(posedge clk);
    if (push) begin
      if (sel == 0) begin exp_q0.push_back(exp); lat_q0.push_back(ncyc); end
      else          begin exp_q1.push_back(exp); lat_q1.push_back(ncyc); end
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || !s_ready0 || !s_ready1) && budget < 100) begin
      tick();
      budget++;
    end
    if (budget >= 100) fail_now("drain timeout");
  endtask

  // ---------------- stimulus ----------------
  logic [OW-1:0] sat_e [4];
  int            budget;

  initial begin
`ifdef MAC_FIR_SATURATE_EN
    sat_e[0] = 16'sd32767; sat_e[1] = 16'sd32767; sat_e[2] = 16'sd32767; sat_e[3] = 16'sd32767;
`else
    sat_e[0] = -16'sd1000; sat_e[1] = -16'sd2000; sat_e[2] = -16'sd3000; sat_e[3] = -16'sd4000;
`endif

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst s_ready", s_ready0, 1);
    check("rst m_valid", m_valid0, 0);
    check("rst m_data", m_data0, 0);
    check("rst coeff_busy", busy0, 0);
    check("rst state", dbg0, 0);
    check("rst s_ready dut1", s_ready1, 1);
    rst_n = 1'b1;
    tick();

    // Impulse: coeffs {1,2,3,4}
    for (int i = 0; i < 4; i++) write_coeff(2'(i), CW'(i + 1));
    send(16'd1, 16'd1, 1);
    check("coeff_busy in RUN", busy0, 1);
    check("s_ready in RUN", s_ready0, 0);
    send(16'd0, 16'd2, 1);
    send(16'd0, 16'd3, 1);
    send(16'd0, 16'd4, 1);
    send(16'd0, 16'd0, 1);
    drain();

    // Backpressure: hold m_ready low in DONE
    m_ready = 1'b0;
    send(16'd5, 16'd5, 1);
    budget = 0;
    while (!m_valid0 && budget < 20) begin tick(); budget++; end
    if (budget >= 20) fail_now("m_valid timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp m_valid", m_valid0, 1);
      check("bp m_data", m_data0, 5);
      check("bp s_ready", s_ready0, 0);
      tick();
    end
    check("bp state DONE", dbg0, 2);
    m_ready = 1'b1;
    tick();
    check("bp release m_valid", m_valid0, 0);
    check("bp release s_ready", s_ready0, 1);

    // Coefficient write during RUN is dropped; in IDLE it applies to the next sample
    send(16'd2, 16'd12, 1);
    tick();
    coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = CW'(99);
    check("busy during write", busy0, 1);
    tick();
    coeff_we = 1'b0;
    send(16'd1, 16'd20, 1);
    drain();
    write_coeff(2'd0, CW'(99));
    send(16'd1, 16'd127, 1);
    drain();

    // Reset at k=2 aborts; coefficients and delay line cleared
    send(16'd7, 16'd0, 0);
    tick();
    tick();
    check("k2 state RUN", dbg0, 1);
    rst_n = 1'b0;
    #1;
    check("abort s_ready", s_ready0, 1);
    check("abort m_valid", m_valid0, 0);
    check("abort m_data", m_data0, 0);
    check("abort coeff_busy", busy0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(16'd1, 16'd0, 1);
    send(16'd0, 16'd0, 1);
    send(16'd0, 16'd0, 1);
    send(16'd0, 16'd0, 1);
    drain();
    for (int i = 0; i < 4; i++) write_coeff(2'(i), CW'(i + 1));
    send(16'd1, 16'd1, 1);
    send(16'd0, 16'd2, 1);
    send(16'd0, 16'd3, 1);
    send(16'd0, 16'd4, 1);
    drain();

    // Saturation / wrap: coeffs 1000, samples 32767
    for (int i = 0; i < 4; i++) write_coeff(2'(i), CW'(1000));
    for (int i = 0; i < 4; i++) send(16'sd32767, sat_e[i], 1);
    drain();

    // Rounding on the OUT_SHIFT=1 instance, coeffs {1,0,0,0}
    sel = 1;
    write_coeff(2'd0, CW'(1));
    send(16'sd3, 16'sd2, 1);
    send(-16'sd3, -16'sd1, 1);
    send(16'sd2, 16'sd1, 1);
    drain();
    check("dut0 idle during dut1 run", m_valid0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
